// File: rtl/axil_read_arbiter_if.sv
// Bundle of AXI-Lite read signals around the two-requester read arbiter:
// the two requester-facing slave ports (packed side by side, slice 0 = CPU,
// slice 1 = graphic system) and the single memory-facing master port.
interface axil_read_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [2*ADDR_WIDTH-1:0] s_axil_araddr;
   logic [1:0]              s_axil_arvalid;
   logic [1:0]              s_axil_arready;
   logic [2*DATA_WIDTH-1:0] s_axil_rdata;
   logic [3:0]              s_axil_rresp;
   logic [1:0]              s_axil_rvalid;
   logic [1:0]              s_axil_rready;
   logic [ADDR_WIDTH-1:0]   m_axil_araddr;
   logic [2:0]              m_axil_arprot;
   logic                    m_axil_arvalid;
   logic                    m_axil_arready;
   logic [DATA_WIDTH-1:0]   m_axil_rdata;
   logic [1:0]              m_axil_rresp;
   logic                    m_axil_rvalid;
   logic                    m_axil_rready;

   // The arbiter's view: responder to the requesters, initiator to memory.
   modport slave (
      input  s_axil_araddr, s_axil_arvalid, s_axil_rready,
      output s_axil_arready, s_axil_rdata, s_axil_rresp, s_axil_rvalid,
      output m_axil_araddr, m_axil_arprot, m_axil_arvalid, m_axil_rready,
      input  m_axil_arready, m_axil_rdata, m_axil_rresp, m_axil_rvalid
   );

   // The surroundings' view: requesters plus the shared memory.
   modport master (
      output s_axil_araddr, s_axil_arvalid, s_axil_rready,
      input  s_axil_arready, s_axil_rdata, s_axil_rresp, s_axil_rvalid,
      input  m_axil_araddr, m_axil_arprot, m_axil_arvalid, m_axil_rready,
      output m_axil_arready, m_axil_rdata, m_axil_rresp, m_axil_rvalid
   );
endinterface

// File: rtl/axil_read_arbiter.sv
// Shares one AXI-Lite read channel between a CPU (slice 0) and a graphic
// system (slice 1). One transaction is in flight at a time; ties are broken
// round-robin against the requester that was served last.
module axil_read_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                aclk,
   input  logic                aresetn,
   axil_read_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   state_t                  state_q, state_d;
   logic                    grant_q;
   logic                    last_grant_q;
   logic                    grant_sel;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [ADDR_WIDTH-1:0]   addr_sel;
   logic                    any_req;
   logic                    r_hs;
   logic [1:0]              arready;
   logic [1:0]              rvalid;
   logic [2*DATA_WIDTH-1:0] rdata;
   logic [3:0]              rresp;
   logic                    m_rready;

   // A lone requester wins outright; on a tie the one not served last wins.
   assign any_req   = |bus.s_axil_arvalid;
   assign grant_sel = (&bus.s_axil_arvalid) ? ~last_grant_q : bus.s_axil_arvalid[1];
   assign addr_sel  = grant_sel ? bus.s_axil_araddr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                : bus.s_axil_araddr[ADDR_WIDTH-1:0];
   assign r_hs      = (state_q == DATA) && bus.m_axil_rvalid && m_rready;

   // Next-state decode plus all requester-side and R-channel steering.
   always_comb begin
      state_d  = state_q;
      arready  = '0;
      rvalid   = '0;
      rdata    = '0;
      rresp    = '0;
      m_rready = 1'b0;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               arready[grant_sel] = 1'b1;
               state_d            = ADDR;
            end
         end
         ADDR: begin
            if (bus.m_axil_arready) state_d = DATA;
         end
         DATA: begin
            rvalid[grant_q] = bus.m_axil_rvalid;
            m_rready        = bus.s_axil_rready[grant_q];
            if (grant_q) begin
               rdata[2*DATA_WIDTH-1:DATA_WIDTH] = bus.m_axil_rdata;
               rresp[3:2]                       = bus.m_axil_rresp;
            end else begin
               rdata[DATA_WIDTH-1:0] = bus.m_axil_rdata;
               rresp[1:0]            = bus.m_axil_rresp;
            end
            if (bus.m_axil_rvalid && bus.s_axil_rready[grant_q]) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // arready is combinational from arvalid, so it must be masked while
      // reset is held to keep a requester from seeing a phantom acceptance.
      if (!aresetn) arready = '0;
   end

   // State, grant bookkeeping and the captured address.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q      <= IDLE;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         addr_q       <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && any_req) begin
            grant_q <= grant_sel;
            addr_q  <= addr_sel;
         end
         if (r_hs) last_grant_q <= grant_q;
      end
   end

   assign bus.s_axil_arready = arready;
   assign bus.s_axil_rvalid  = rvalid;
   assign bus.s_axil_rdata   = rdata;
   assign bus.s_axil_rresp   = rresp;
   assign bus.m_axil_rready  = m_rready;
   assign bus.m_axil_araddr  = addr_q;
   assign bus.m_axil_arprot  = 3'b000;
   assign bus.m_axil_arvalid = (state_q == ADDR);

endmodule

// File: tb/tb_axil_read_arbiter.sv
// Directed bench for the two-requester AXI-Lite read arbiter.
module tb_axil_read_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;

   logic aclk;
   logic aresetn;
   int   n_chk;
   int   n_err;
   int   ar_hs;
   logic [AW-1:0] addr_cpu;
   logic [AW-1:0] addr_gfx;

   axil_read_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   axil_read_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .aclk    (aclk),
      .aresetn (aresetn),
      .bus     (bus)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   // Count memory-side AR handshakes.
   always @(posedge aclk) begin
      if (bus.m_axil_arvalid && bus.m_axil_arready) ar_hs <= ar_hs + 1;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One full transaction starting at a negedge in IDLE with arvalid already
   // driven. exp_g is the requester that must win; after_req is the arvalid
   // pattern applied once the grant has been taken.
   task automatic txn(input int exp_g, input logic [31:0] data, input logic [1:0] resp,
                      input int ar_wait, input int r_hold, input logic [1:0] after_req);
      logic [1:0]    exp_one;
      logic [63:0]   exp_data;
      logic [3:0]    exp_resp;
      logic [AW-1:0] exp_addr;
      exp_one  = (exp_g == 1) ? 2'b10 : 2'b01;
      exp_data = (exp_g == 1) ? {data, 32'h0} : {32'h0, data};
      exp_resp = (exp_g == 1) ? {resp, 2'b00} : {2'b00, resp};
      exp_addr = (exp_g == 1) ? addr_gfx : addr_cpu;
      #1;
      check("grant_arready", bus.s_axil_arready, exp_one);
      check("idle_arvalid", bus.m_axil_arvalid, 1'b0);
      @(negedge aclk);
      bus.s_axil_arvalid = after_req;
      bus.m_axil_arready = 1'b0;
      for (int i = 0; i < ar_wait; i++) begin
         #1;
         check("addr_wait_arvalid", bus.m_axil_arvalid, 1'b1);
         check("addr_wait_araddr", bus.m_axil_araddr, exp_addr);
         check("addr_wait_arready", bus.s_axil_arready, 2'b00);
         @(negedge aclk);
      end
      bus.m_axil_arready = 1'b1;
      #1;
      check("addr_arvalid", bus.m_axil_arvalid, 1'b1);
      check("addr_araddr", bus.m_axil_araddr, exp_addr);
      check("addr_arprot", bus.m_axil_arprot, 3'b000);
      check("addr_arready", bus.s_axil_arready, 2'b00);
      check("addr_rvalid", bus.s_axil_rvalid, 2'b00);
      @(negedge aclk);
      bus.m_axil_arready = 1'b0;
      bus.m_axil_rvalid  = 1'b1;
      bus.m_axil_rdata   = data;
      bus.m_axil_rresp   = resp;
      bus.s_axil_rready  = 2'b00;
      for (int i = 0; i < r_hold; i++) begin
         #1;
         check("hold_m_rready", bus.m_axil_rready, 1'b0);
         check("hold_rvalid", bus.s_axil_rvalid, exp_one);
         check("hold_arready", bus.s_axil_arready, 2'b00);
         check("hold_arvalid", bus.m_axil_arvalid, 1'b0);
         @(negedge aclk);
      end
      bus.s_axil_rready = 2'b11;
      #1;
      check("data_rvalid", bus.s_axil_rvalid, exp_one);
      check("data_m_rready", bus.m_axil_rready, 1'b1);
      check("data_rdata", bus.s_axil_rdata, exp_data);
      check("data_rresp", bus.s_axil_rresp, exp_resp);
      check("data_arready", bus.s_axil_arready, 2'b00);
      @(negedge aclk);
      bus.m_axil_rvalid = 1'b0;
      bus.s_axil_rready = 2'b00;
      #1;
      check("post_rvalid", bus.s_axil_rvalid, 2'b00);
      check("post_m_rready", bus.m_axil_rready, 1'b0);
      #1;
   endtask

   task automatic apply_reset();
      @(negedge aclk);
      aresetn = 1'b0;
      bus.s_axil_arvalid = 2'b11;
      bus.m_axil_rvalid  = 1'b1;
      bus.s_axil_rready  = 2'b11;
      #1;
      check("rst_arready", bus.s_axil_arready, 2'b00);
      check("rst_arvalid", bus.m_axil_arvalid, 1'b0);
      check("rst_rvalid", bus.s_axil_rvalid, 2'b00);
      check("rst_m_rready", bus.m_axil_rready, 1'b0);
      check("rst_araddr", bus.m_axil_araddr, '0);
      @(negedge aclk);
      bus.s_axil_arvalid = 2'b00;
      bus.m_axil_rvalid  = 1'b0;
      bus.s_axil_rready  = 2'b00;
      aresetn = 1'b1;
   endtask

   initial begin
      int hs0;
      n_chk = 0;
      n_err = 0;
      ar_hs = 0;
      aresetn = 1'b0;
      addr_cpu = 32'h0000_0040;
      addr_gfx = 32'h0000_0200;
      bus.s_axil_araddr  = {addr_gfx, addr_cpu};
      bus.s_axil_arvalid = 2'b00;
      bus.s_axil_rready  = 2'b00;
      bus.m_axil_arready = 1'b0;
      bus.m_axil_rdata   = '0;
      bus.m_axil_rresp   = '0;
      bus.m_axil_rvalid  = 1'b0;
      repeat (2) @(negedge aclk);
      apply_reset();
      @(negedge aclk);

      // CPU alone reads 0x40 and gets 0xDEADBEEF, slice 1 stays zero.
      bus.s_axil_arvalid = 2'b01;
      txn(0, 32'hDEAD_BEEF, 2'b00, 0, 2, 2'b00);

      // Both requesters hold arvalid: round-robin 0,1,0,1 after a fresh reset.
      apply_reset();
      addr_cpu = 32'h0000_0100;
      addr_gfx = 32'h0000_0280;
      bus.s_axil_araddr  = {addr_gfx, addr_cpu};
      bus.s_axil_arvalid = 2'b11;
      txn(0, 32'h1111_0000, 2'b00, 0, 0, 2'b11);
      txn(1, 32'h2222_0001, 2'b10, 0, 0, 2'b11);
      txn(0, 32'h3333_0002, 2'b00, 0, 0, 2'b11);
      txn(1, 32'h4444_0003, 2'b11, 0, 0, 2'b00);

      // Memory stalls arready for 5 cycles; exactly one AR handshake.
      hs0 = ar_hs;
      addr_gfx = 32'hABCD_0010;
      bus.s_axil_araddr  = {addr_gfx, addr_cpu};
      bus.s_axil_arvalid = 2'b10;
      txn(1, 32'h5A5A_A5A5, 2'b00, 5, 0, 2'b00);
      check("ar_handshakes", ar_hs - hs0, 1);

      // Graphic back-pressures R for 4 cycles while the CPU waits.
      bus.s_axil_arvalid = 2'b10;
      txn(1, 32'hCAFE_F00D, 2'b01, 0, 4, 2'b01);
      txn(0, 32'h0BAD_CAFE, 2'b00, 0, 0, 2'b00);

      // Reset during ADDR abandons the transaction; next tie goes to 0.
      bus.s_axil_arvalid = 2'b01;
      #1;
      check("pre_rst_arready", bus.s_axil_arready, 2'b01);
      @(negedge aclk);
      bus.s_axil_arvalid = 2'b00;
      #1;
      check("pre_rst_addr", bus.m_axil_arvalid, 1'b1);
      #1;
      aresetn = 1'b0;
      #1;
      check("mid_rst_arvalid", bus.m_axil_arvalid, 1'b0);
      check("mid_rst_araddr", bus.m_axil_araddr, '0);
      @(negedge aclk);
      bus.m_axil_rvalid = 1'b1;
      bus.s_axil_rready = 2'b11;
      #1;
      check("mid_rst_rvalid", bus.s_axil_rvalid, 2'b00);
      @(negedge aclk);
      bus.m_axil_rvalid = 1'b0;
      bus.s_axil_rready = 2'b00;
      aresetn = 1'b1;
      @(negedge aclk);
      bus.s_axil_arvalid = 2'b11;
      txn(0, 32'h7777_8888, 2'b00, 1, 1, 2'b00);

      repeat (2) @(negedge aclk);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/axil_read_arbiter.md
AXIL_READ_ARBITER -- requirements
Module: axil_read_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, is the address width per port.
REQ-002 Parameter DATA_WIDTH, default 32, is the read data width per port.
REQ-003 aclk  input  1  single clock for all logic.
REQ-004 aresetn  input  1  reset, asynchronous assert, active-low.
REQ-005 s_axil_araddr  input  2*ADDR_WIDTH  per-requester read address; slice 0 = CPU, slice 1 = graphic system.
REQ-006 s_axil_arvalid  input  2  per-requester AR valid.
REQ-007 s_axil_arready  output  2  per-requester AR ready.
REQ-008 s_axil_rdata  output  2*DATA_WIDTH  per-requester read data.
REQ-009 s_axil_rresp  output  4  per-requester read response, 2 bits each.
REQ-010 s_axil_rvalid  output  2  per-requester R valid.
REQ-011 s_axil_rready  input  2  per-requester R ready.
REQ-012 m_axil_araddr  output  ADDR_WIDTH  address to the shared memory.
REQ-013 m_axil_arprot  output  3  protection bits; constant 3'b000.
REQ-014 m_axil_arvalid  output  1  AR valid to memory.
REQ-015 m_axil_arready  input  1  AR ready from memory.
REQ-016 m_axil_rdata  input  DATA_WIDTH  read data from memory.
REQ-017 m_axil_rresp  input  2  read response from memory.
REQ-018 m_axil_rvalid  input  1  R valid from memory.
REQ-019 m_axil_rready  output  1  R ready to memory.

Function
REQ-020 The block SHALL share one AXI-Lite read channel between two requesters, with exactly one transaction outstanding.
REQ-021 The FSM SHALL have three states: IDLE, ADDR and DATA.
REQ-022 In IDLE, with any s_axil_arvalid high, grant g SHALL be the only requester, or on a tie the requester not equal to last_grant.
REQ-023 In that same IDLE cycle, s_axil_arready[g] SHALL be high combinationally; the address SHALL be registered; the next state SHALL be ADDR with m_axil_arvalid high from the next cycle.
REQ-024 s_axil_arready SHALL be 0 for the non-granted requester, and 0 for both requesters in ADDR and DATA.
REQ-025 In ADDR, m_axil_arvalid and m_axil_araddr SHALL stay stable until m_axil_arready; on that handshake m_axil_arvalid drops and the state goes to DATA.
REQ-026 In DATA, s_axil_rvalid[g]=m_axil_rvalid, m_axil_rready=s_axil_rready[g], and rdata/rresp of slice g SHALL equal the memory values.
REQ-027 In DATA, the non-granted slices of rdata and rresp SHALL be 0, and their rvalid SHALL be 0.
REQ-028 On an R handshake (m_axil_rvalid && m_axil_rready), last_grant SHALL become g and the state SHALL return to IDLE.
REQ-029 A new grant SHALL NOT occur in the handshake cycle itself; minimum spacing between grants is 3 cycles.
REQ-030 A requester dropping arvalid before its grant SHALL have no effect.
REQ-031 A back-pressured response (s_axil_rready[g] low) SHALL hold DATA indefinitely, with no timeout.
REQ-032 Outside DATA, m_axil_rready and all s_axil_rvalid SHALL be 0.

Reset
REQ-033 aresetn low SHALL immediately force state=IDLE, last_grant=1, m_axil_arvalid=0, address register=0.
REQ-034 Reset SHALL force all s_axil_arready, s_axil_rvalid and m_axil_rready to 0.
REQ-035 Reset mid-transaction SHALL abandon the transaction, with no response delivered to the requester.
REQ-036 After reset release, the first tie SHALL grant requester 0.

Verification
REQ-037 Only CPU requests 0x0000_0040, memory arready at once, rvalid 2 cycles later with 0xDEADBEEF -> s_axil_rdata[31:0]=0xDEADBEEF with s_axil_rvalid=2'b01; slice 1 stays 0.
REQ-038 Both requesters hold arvalid continuously after reset -> grant order 0,1,0,1 over four transactions, each arready one cycle wide.
REQ-039 Memory holds arready low 5 cycles -> m_axil_arvalid high and m_axil_araddr unchanged for all 5 cycles; exactly one AR handshake.
REQ-040 Requester 1 in DATA holds rready low 4 cycles while m_axil_rvalid high -> m_axil_rready low, state held, no grant to requester 0 until the handshake.
REQ-041 aresetn pulsed low during ADDR -> m_axil_arvalid=0 the same cycle; after release, a tie grants requester 0.
